// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: state codes, datapath
// select encodings, opcode/funct values and the one-hot instruction classes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_RA  = 2'd2;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MDR = 2'd1;
  localparam logic [1:0] SRC_PC4 = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  localparam logic [2:0] NPC_PC4 = 3'd0;
  localparam logic [2:0] NPC_BEQ = 3'd1;
  localparam logic [2:0] NPC_J   = 3'd2;
  localparam logic [2:0] NPC_JR  = 3'd3;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_JAL  = 6'h03;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_NOP  = 6'h00;

  // Bit positions of the one-hot instruction class vector.
  localparam int C_R_ADD = 0;
  localparam int C_R_SUB = 1;
  localparam int C_JR    = 2;
  localparam int C_NOP   = 3;
  localparam int C_ORI   = 4;
  localparam int C_LUI   = 5;
  localparam int C_LW    = 6;
  localparam int C_SW    = 7;
  localparam int C_BEQ   = 8;
  localparam int C_JAL   = 9;
  localparam int C_ILL   = 10;
  localparam int NCLS    = 11;

  typedef logic [NCLS-1:0] cls_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct decoder producing exactly one active class bit;
// anything not recognised lands in the ILL class.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_R: begin
        case (funct)
          FN_ADDU, FN_ADD: cls[C_R_ADD] = 1'b1;
          FN_SUBU, FN_SUB: cls[C_R_SUB] = 1'b1;
          FN_JR:           cls[C_JR]    = 1'b1;
          FN_NOP:          cls[C_NOP]   = 1'b1;
          default:         cls[C_ILL]   = 1'b1;
        endcase
      end
      OP_ORI:  cls[C_ORI] = 1'b1;
      OP_LUI:  cls[C_LUI] = 1'b1;
      OP_LW:   cls[C_LW]  = 1'b1;
      OP_SW:   cls[C_SW]  = 1'b1;
      OP_BEQ:  cls[C_BEQ] = 1'b1;
      OP_JAL:  cls[C_JAL] = 1'b1;
      default: cls[C_ILL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencer: walks FETCH/DECODE/EXEC/MEM/WB per instruction class,
// drives the datapath enables and counts retired instructions.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             MDRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       RegSrc,
  output logic             ALUSrc,
  output logic [2:0]       ALUCtrl,
  output logic             ExtOp,
  output logic [2:0]       nPC_Sel,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             illegal
);

  cls_t   cls;
  state_t cur, nxt;
  logic   ir_w, pc_w, mdr_w, reg_w, mem_w, set_ill;
  logic   is_r, is_mem, alu_on;
  logic   unused_zero;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  // The zero flag goes straight to NPC; the sequencer never branches on it.
  assign unused_zero = zero;
  assign is_r        = cls[C_R_ADD] | cls[C_R_SUB];
  assign is_mem      = cls[C_LW] | cls[C_SW];
  assign alu_on      = (cur == S_EXEC) || (cur == S_MEM) || (cur == S_WB);

  always_comb begin
    nxt     = S_FETCH;
    ir_w    = 1'b0;
    pc_w    = 1'b0;
    mdr_w   = 1'b0;
    reg_w   = 1'b0;
    mem_w   = 1'b0;
    set_ill = 1'b0;
    RegDst  = DST_RT;
    RegSrc  = SRC_ALU;
    nPC_Sel = NPC_PC4;
    case (cur)
      S_FETCH: begin
        ir_w = 1'b1;
        nxt  = S_DECODE;
      end
      S_DECODE: begin
        if (cls[C_JR]) begin
          pc_w    = 1'b1;
          nPC_Sel = NPC_JR;
        end else if (cls[C_NOP] || cls[C_ILL]) begin
          pc_w    = 1'b1;
          set_ill = cls[C_ILL];
        end else if (cls[C_JAL]) begin
          nxt = S_WB;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls[C_BEQ]) begin
          pc_w    = 1'b1;
          nPC_Sel = NPC_BEQ;
        end else if (is_mem) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        // Strobes are held for the whole wait so DM sees a stable request.
        mem_w = cls[C_SW];
        mdr_w = cls[C_LW];
        if (!mem_ready) nxt = S_MEM;
        else if (cls[C_LW]) nxt = S_WB;
        else pc_w = 1'b1;
      end
      S_WB: begin
        reg_w = 1'b1;
        pc_w  = 1'b1;
        if (is_r) begin
          RegDst = DST_RD;
        end else if (cls[C_JAL]) begin
          RegDst  = DST_RA;
          RegSrc  = SRC_PC4;
          nPC_Sel = NPC_J;
        end
        if (cls[C_LW]) RegSrc = SRC_MDR;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // ALU operand/operation selects stay valid from EXEC through WB.
  always_comb begin
    ALUSrc  = alu_on & (cls[C_ORI] | cls[C_LUI] | is_mem);
    ExtOp   = alu_on & (is_mem | cls[C_BEQ]);
    ALUCtrl = ALU_ADD;
    if (alu_on) begin
      if (cls[C_R_SUB] || cls[C_BEQ]) ALUCtrl = ALU_SUB;
      else if (cls[C_ORI])            ALUCtrl = ALU_OR;
      else if (cls[C_LUI])            ALUCtrl = ALU_LUI;
    end
  end

  assign IRWrite  = ir_w  & ~reset;
  assign PCWrite  = pc_w  & ~reset;
  assign MDRWrite = mdr_w & ~reset;
  assign RegWrite = reg_w & ~reset;
  assign MemWrite = mem_w & ~reset;
  assign state    = cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur       <= S_FETCH;
      instr_cnt <= '0;
      illegal   <= 1'b0;
    end else begin
      cur <= nxt;
      if (pc_w) instr_cnt <= instr_cnt + CNT_W'(1);
      if (set_ill) illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle control-word traces for each
// instruction class, plus counter, sticky-illegal and mid-instruction reset.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        IRWrite, PCWrite, MDRWrite, RegWrite, MemWrite;
  logic [1:0]  RegDst, RegSrc;
  logic        ALUSrc, ExtOp;
  logic [2:0]  ALUCtrl, nPC_Sel, state;
  logic [31:0] instr_cnt;
  logic        illegal;

  // {state, IRW, PCW, MDRW, RegW, MemW, RegDst, RegSrc, ALUSrc, ALUCtrl, ExtOp, nPC_Sel}
  logic [19:0] obs;
  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_cnt = '0;

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .MDRWrite  (MDRWrite),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .RegDst    (RegDst),
    .RegSrc    (RegSrc),
    .ALUSrc    (ALUSrc),
    .ALUCtrl   (ALUCtrl),
    .ExtOp     (ExtOp),
    .nPC_Sel   (nPC_Sel),
    .state     (state),
    .instr_cnt (instr_cnt),
    .illegal   (illegal)
  );

  assign obs = {state, IRWrite, PCWrite, MDRWrite, RegWrite, MemWrite,
                RegDst, RegSrc, ALUSrc, ALUCtrl, ExtOp, nPC_Sel};

  function automatic logic [19:0] cw(input int st, input logic [4:0] sb, input int dst,
                                     input int src, input int asrc, input int actl,
                                     input int ext, input int npc);
    return {st[2:0], sb, dst[1:0], src[1:0], asrc[0], actl[2:0], ext[0], npc[2:0]};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (obs !== cw(0, 5'b00000, 0, 0, 0, 0, 0, 0))
      $display("FAIL reset_word: got %h want %h", obs, cw(0, 5'b00000, 0, 0, 0, 0, 0, 0));
    else passes++;
    checks++;
    if (instr_cnt !== 32'd0) $display("FAIL reset_cnt: got %0d want 0", instr_cnt);
    else passes++;
    checks++;
    if (illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", illegal);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== cw(0, 5'b10000, 0, 0, 0, 0, 0, 0))
      $display("FAIL fetch_after_reset: got %h want %h", obs, cw(0, 5'b10000, 0, 0, 0, 0, 0, 0));
    else passes++;
  endtask

  task automatic test_addu();
    logic [19:0] ew [4];
    ew[0] = cw(0, 5'b10000, 0, 0, 0, 0, 0, 0);
    ew[1] = cw(1, 5'b00000, 0, 0, 0, 0, 0, 0);
    ew[2] = cw(2, 5'b00000, 0, 0, 0, 0, 0, 0);
    ew[3] = cw(4, 5'b01010, 1, 0, 0, 0, 0, 0);
    opcode = 6'h00; funct = 6'h21; mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== ew[i]) $display("FAIL addu_c%0d: got %h want %h", i, obs, ew[i]);
      else passes++;
      step();
    end
    exp_cnt = exp_cnt + 1;
    checks++;
    if (state !== 3'd0 || instr_cnt !== exp_cnt)
      $display("FAIL addu_end: state %0d cnt %0d want state 0 cnt %0d", state, instr_cnt, exp_cnt);
    else passes++;
  endtask

  task automatic test_lw();
    logic [19:0] ew [8];
    ew[0] = cw(0, 5'b10000, 0, 0, 0, 0, 0, 0);
    ew[1] = cw(1, 5'b00000, 0, 0, 0, 0, 0, 0);
    ew[2] = cw(2, 5'b00000, 0, 0, 1, 0, 1, 0);
    for (int i = 3; i < 7; i++) ew[i] = cw(3, 5'b00100, 0, 0, 1, 0, 1, 0);
    ew[7] = cw(4, 5'b01010, 0, 1, 1, 0, 1, 0);
    opcode = 6'h23; funct = 6'h05;
    for (int i = 0; i < 8; i++) begin
      mem_ready = !(i >= 3 && i <= 5);
      #1;
      checks++;
      if (obs !== ew[i]) $display("FAIL lw_c%0d: got %h want %h", i, obs, ew[i]);
      else passes++;
      step();
    end
    exp_cnt = exp_cnt + 1;
    checks++;
    if (state !== 3'd0 || instr_cnt !== exp_cnt)
      $display("FAIL lw_end: state %0d cnt %0d want state 0 cnt %0d", state, instr_cnt, exp_cnt);
    else passes++;
  endtask

  task automatic test_beq();
    logic [19:0] ew [3];
    ew[0] = cw(0, 5'b10000, 0, 0, 0, 0, 0, 0);
    ew[1] = cw(1, 5'b00000, 0, 0, 0, 0, 0, 0);
    ew[2] = cw(2, 5'b01000, 0, 0, 0, 1, 1, 1);
    opcode = 6'h04; funct = 6'h3C; mem_ready = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs !== ew[i]) $display("FAIL beq_z%0d_c%0d: got %h want %h", z, i, obs, ew[i]);
        else passes++;
        step();
      end
      exp_cnt = exp_cnt + 1;
      checks++;
      if (state !== 3'd0 || instr_cnt !== exp_cnt)
        $display("FAIL beq_z%0d_end: state %0d cnt %0d want state 0 cnt %0d", z, state, instr_cnt, exp_cnt);
      else passes++;
    end
    zero = 1'b0;
  endtask

  task automatic test_jal_jr();
    logic [19:0] ej [3];
    logic [19:0] er [2];
    ej[0] = cw(0, 5'b10000, 0, 0, 0, 0, 0, 0);
    ej[1] = cw(1, 5'b00000, 0, 0, 0, 0, 0, 0);
    ej[2] = cw(4, 5'b01010, 2, 2, 0, 0, 0, 2);
    er[0] = cw(0, 5'b10000, 0, 0, 0, 0, 0, 0);
    er[1] = cw(1, 5'b01000, 0, 0, 0, 0, 0, 3);
    opcode = 6'h03; funct = 6'h00;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== ej[i]) $display("FAIL jal_c%0d: got %h want %h", i, obs, ej[i]);
      else passes++;
      step();
    end
    opcode = 6'h00; funct = 6'h08;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== er[i]) $display("FAIL jr_c%0d: got %h want %h", i, obs, er[i]);
      else passes++;
      step();
    end
    exp_cnt = exp_cnt + 2;
    checks++;
    if (state !== 3'd0 || instr_cnt !== exp_cnt)
      $display("FAIL jal_jr_end: state %0d cnt %0d want state 0 cnt %0d", state, instr_cnt, exp_cnt);
    else passes++;
  endtask

  task automatic test_sw();
    logic [19:0] ew [4];
    ew[0] = cw(0, 5'b10000, 0, 0, 0, 0, 0, 0);
    ew[1] = cw(1, 5'b00000, 0, 0, 0, 0, 0, 0);
    ew[2] = cw(2, 5'b00000, 0, 0, 1, 0, 1, 0);
    ew[3] = cw(3, 5'b01001, 0, 0, 1, 0, 1, 0);
    opcode = 6'h2B; funct = 6'h10; mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== ew[i]) $display("FAIL sw_c%0d: got %h want %h", i, obs, ew[i]);
      else passes++;
      step();
    end
    exp_cnt = exp_cnt + 1;
    checks++;
    if (state !== 3'd0 || instr_cnt !== exp_cnt)
      $display("FAIL sw_end: state %0d cnt %0d want state 0 cnt %0d", state, instr_cnt, exp_cnt);
    else passes++;
  endtask

  // subu, ori, lui: same 4-cycle shape, differing in ALU op, operand and dest.
  task automatic test_alu_ops();
    int ops   [3] = '{'h00, 'h0D, 'h0F};
    int fns   [3] = '{'h23, 'h00, 'h00};
    int actl  [3] = '{1, 2, 3};
    int asrc  [3] = '{0, 1, 1};
    int dst   [3] = '{1, 0, 0};
    logic [19:0] ew [4];
    int op_v, fn_v;
    for (int k = 0; k < 3; k++) begin
      ew[0] = cw(0, 5'b10000, 0, 0, 0, 0, 0, 0);
      ew[1] = cw(1, 5'b00000, 0, 0, 0, 0, 0, 0);
      ew[2] = cw(2, 5'b00000, 0, 0, asrc[k], actl[k], 0, 0);
      ew[3] = cw(4, 5'b01010, dst[k], 0, asrc[k], actl[k], 0, 0);
      op_v = ops[k];
      fn_v = fns[k];
      opcode = op_v[5:0]; funct = fn_v[5:0];
      #1;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs !== ew[i]) $display("FAIL alu_op%0d_c%0d: got %h want %h", k, i, obs, ew[i]);
        else passes++;
        step();
      end
    end
    exp_cnt = exp_cnt + 3;
    checks++;
    if (instr_cnt !== exp_cnt) $display("FAIL alu_ops_cnt: got %0d want %0d", instr_cnt, exp_cnt);
    else passes++;
  endtask

  task automatic test_illegal();
    logic [19:0] ew [2];
    ew[0] = cw(0, 5'b10000, 0, 0, 0, 0, 0, 0);
    ew[1] = cw(1, 5'b01000, 0, 0, 0, 0, 0, 0);
    opcode = 6'h3F; funct = 6'h21;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== ew[i]) $display("FAIL ill_c%0d: got %h want %h", i, obs, ew[i]);
      else passes++;
      step();
    end
    checks++;
    if (illegal !== 1'b1) $display("FAIL ill_flag: got %b want 1", illegal);
    else passes++;
    opcode = 6'h00; funct = 6'h00;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== ew[i]) $display("FAIL nop_c%0d: got %h want %h", i, obs, ew[i]);
      else passes++;
      step();
    end
    exp_cnt = exp_cnt + 2;
    checks++;
    if (illegal !== 1'b1 || instr_cnt !== exp_cnt)
      $display("FAIL ill_sticky: illegal %b cnt %0d want illegal 1 cnt %0d", illegal, instr_cnt, exp_cnt);
    else passes++;
  endtask

  task automatic test_reset_mid_mem();
    logic [19:0] ew [4];
    ew[0] = cw(0, 5'b10000, 0, 0, 0, 0, 0, 0);
    ew[1] = cw(1, 5'b00000, 0, 0, 0, 0, 0, 0);
    ew[2] = cw(2, 5'b00000, 0, 0, 1, 0, 1, 0);
    ew[3] = cw(3, 5'b00001, 0, 0, 1, 0, 1, 0);
    opcode = 6'h2B; funct = 6'h00; mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== ew[i]) $display("FAIL rst_sw_c%0d: got %h want %h", i, obs, ew[i]);
      else passes++;
      if (i < 3) step();
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== cw(0, 5'b00000, 0, 0, 0, 0, 0, 0))
      $display("FAIL rst_mid_word: got %h want %h", obs, cw(0, 5'b00000, 0, 0, 0, 0, 0, 0));
    else passes++;
    checks++;
    if (instr_cnt !== 32'd0 || illegal !== 1'b0)
      $display("FAIL rst_mid_regs: cnt %0d illegal %b want cnt 0 illegal 0", instr_cnt, illegal);
    else passes++;
    step();
    reset = 1'b0;
    mem_ready = 1'b1;
    step();
    checks++;
    if (state !== 3'd1 || instr_cnt !== 32'd0)
      $display("FAIL rst_restart: state %0d cnt %0d want state 1 cnt 0", state, instr_cnt);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw();
    test_beq();
    test_jal_jr();
    test_sw();
    test_alu_ops();
    test_illegal();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
